// File: rtl/bram_s1_arbiter.sv
// Round-robin arbiter for two clients sharing a single-port 4096x1 RAM, with a post-reset/on-demand clear sweep.
// Grants are combinational and reads return one cycle later; requests stall (ACK=0) while BUSY.
module bram_s1_arbiter #(
    parameter int ADDR_W         = 12,
    parameter int CLEAR_ON_RESET = 1,
    parameter bit CLEAR_VAL      = 1'b0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CLR_START,
    output logic              BUSY,
    input  logic              A_REQ,
    input  logic              A_WE,
    input  logic [ADDR_W-1:0] A_ADDR,
    input  logic              A_DI,
    output logic              A_ACK,
    output logic              A_VLD,
    output logic              A_DO,
    input  logic              B_REQ,
    input  logic              B_WE,
    input  logic [ADDR_W-1:0] B_ADDR,
    input  logic              B_DI,
    output logic              B_ACK,
    output logic              B_VLD,
    output logic              B_DO,
    output logic              RAM_EN,
    output logic              RAM_WE,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic              RAM_DI,
    input  logic              RAM_DO
);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    localparam state_t              RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
    localparam logic [ADDR_W-1:0]   LAST_ADDR = '1;

    state_t              state;
    logic [ADDR_W-1:0]   clr_cnt;
    logic                ptr_b;
    logic                a_vld_q, b_vld_q;
    logic                a_do_q, b_do_q;
    logic [ADDR_W-1:0]   last_addr;
    logic                last_di;
    logic                arb_ok, clearing, gnt_a, gnt_b;

    // RST gating keeps the RAM and clients quiet while reset is held.
    assign arb_ok   = (state == S_IDLE) && !CLR_START && !RST;
    assign clearing = (state == S_CLEAR) && !RST;
    assign gnt_a    = arb_ok && A_REQ && (!B_REQ || !ptr_b);
    assign gnt_b    = arb_ok && B_REQ && (!A_REQ || ptr_b);

    assign A_ACK = gnt_a;
    assign B_ACK = gnt_b;
    assign BUSY  = (state == S_CLEAR);
    assign A_VLD = a_vld_q;
    assign B_VLD = b_vld_q;
    assign A_DO  = a_vld_q ? RAM_DO : a_do_q;
    assign B_DO  = b_vld_q ? RAM_DO : b_do_q;

    always_comb begin
        RAM_EN   = 1'b0;
        RAM_WE   = 1'b0;
        RAM_ADDR = last_addr;
        RAM_DI   = last_di;
        if (clearing) begin
            RAM_EN   = 1'b1;
            RAM_WE   = 1'b1;
            RAM_ADDR = clr_cnt;
            RAM_DI   = CLEAR_VAL;
        end else if (gnt_a) begin
            RAM_EN   = 1'b1;
            RAM_WE   = A_WE;
            RAM_ADDR = A_ADDR;
            RAM_DI   = A_DI;
        end else if (gnt_b) begin
            RAM_EN   = 1'b1;
            RAM_WE   = B_WE;
            RAM_ADDR = B_ADDR;
            RAM_DI   = B_DI;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= RST_STATE;
            clr_cnt   <= '0;
            ptr_b     <= 1'b0;
            a_vld_q   <= 1'b0;
            b_vld_q   <= 1'b0;
            a_do_q    <= 1'b0;
            b_do_q    <= 1'b0;
            last_addr <= '0;
            last_di   <= 1'b0;
        end else begin
            last_addr <= RAM_ADDR;
            last_di   <= RAM_DI;
            a_vld_q   <= gnt_a && !A_WE;
            b_vld_q   <= gnt_b && !B_WE;
            if (a_vld_q) a_do_q <= RAM_DO;
            if (b_vld_q) b_do_q <= RAM_DO;
            case (state)
                S_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == LAST_ADDR) state <= S_IDLE;
                end
                default: begin
                    if (CLR_START) begin
                        state   <= S_CLEAR;
                        clr_cnt <= '0;
                    end else if (gnt_a || gnt_b) begin
                        ptr_b <= gnt_a;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_s1_arbiter.sv
// Bench for bram_s1_arbiter: behavioural RAM plus a round-robin/memory reference model.
module tb_bram_s1_arbiter;
    localparam int AW  = 12;
    localparam int DEP = 4096;
    localparam bit CV  = 1'b0;

    logic CLK = 1'b0;
    logic RST, CLR_START, BUSY;
    logic A_REQ, A_WE, A_DI, A_ACK, A_VLD, A_DO;
    logic B_REQ, B_WE, B_DI, B_ACK, B_VLD, B_DO;
    logic [AW-1:0] A_ADDR, B_ADDR, RAM_ADDR;
    logic RAM_EN, RAM_WE, RAM_DI, RAM_DO;

    int n_chk = 0;
    int n_fail = 0;

    bram_s1_arbiter #(.ADDR_W(AW), .CLEAR_ON_RESET(1), .CLEAR_VAL(CV)) dut (
        .CLK(CLK), .RST(RST), .CLR_START(CLR_START), .BUSY(BUSY),
        .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_DI(A_DI),
        .A_ACK(A_ACK), .A_VLD(A_VLD), .A_DO(A_DO),
        .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_DI(B_DI),
        .B_ACK(B_ACK), .B_VLD(B_VLD), .B_DO(B_DO),
        .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR),
        .RAM_DI(RAM_DI), .RAM_DO(RAM_DO)
    );

    always #5 CLK = ~CLK;

    // Single-port write-first RAM with one-cycle read latency.
    logic ram_mem [0:DEP-1];
    always @(posedge CLK) begin
        if (RAM_EN) begin
            if (RAM_WE) begin
                ram_mem[RAM_ADDR] <= RAM_DI;
                RAM_DO <= RAM_DI;
            end else begin
                RAM_DO <= ram_mem[RAM_ADDR];
            end
        end
    end

    // Reference model state.
    bit          mdl_mem [0:DEP-1];
    bit          mdl_ptr_b;
    logic [AW-1:0] mdl_last_addr;
    bit          mdl_last_di;
    bit          exp_avld, exp_bvld, exp_ado, exp_bdo;

    function automatic int arb(input bit ra, input bit rb);
        if (ra && rb) return mdl_ptr_b ? 2 : 1;
        if (ra) return 1;
        if (rb) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        mdl_ptr_b = 0; mdl_last_addr = '0; mdl_last_di = 0;
        exp_avld = 0; exp_bvld = 0; exp_ado = 0; exp_bdo = 0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEP; i++) mdl_mem[i] = CV;
        mdl_last_addr = '1; mdl_last_di = CV;
        exp_avld = 0; exp_bvld = 0;
    endtask

    // Advance the model by one cycle given the grant g (0 none, 1 A, 2 B).
    task automatic model_commit(input int g);
        bit we, di;
        logic [AW-1:0] ad;
        exp_avld = 0; exp_bvld = 0;
        if (g == 0) return;
        we = (g == 1) ? A_WE : B_WE;
        ad = (g == 1) ? A_ADDR : B_ADDR;
        di = (g == 1) ? A_DI : B_DI;
        if (we) mdl_mem[ad] = di;
        else if (g == 1) begin exp_avld = 1; exp_ado = mdl_mem[ad]; end
        else begin exp_bvld = 1; exp_bdo = mdl_mem[ad]; end
        mdl_ptr_b = (g == 1);
        mdl_last_addr = ad; mdl_last_di = di;
    endtask

    // Runs a full sweep starting in the current cycle; pulses CLR_START at index clr_at.
    task automatic test_clear_sweep(input int clr_at);
        int bad = 0;
        for (int i = 0; i < DEP; i++) begin
            if (i > 0) @(negedge CLK);
            CLR_START = (i == clr_at);
            #1;
            if ({BUSY, RAM_EN, RAM_WE, RAM_DI, A_ACK, B_ACK, A_VLD, B_VLD} !== {3'b111, CV, 4'b0000}
                || RAM_ADDR !== AW'(i)) begin
                if (bad == 0) $display("FAIL sweep_step %0d: ctl=%b addr=%0h", i,
                    {BUSY, RAM_EN, RAM_WE, RAM_DI, A_ACK, B_ACK, A_VLD, B_VLD}, RAM_ADDR);
                bad++;
            end
        end
        @(negedge CLK); CLR_START = 0; #1;
        model_clear();
        n_chk++; if (bad != 0) begin n_fail++; $display("FAIL sweep: %0d bad cycles, expected 0", bad); end
        n_chk++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL busy_drop: got %b expected 0", BUSY); end
    endtask

    task automatic test_reset();
        RST = 1; CLR_START = 0;
        A_REQ = 1; A_WE = 0; A_ADDR = 12'h7FF; A_DI = 0;
        B_REQ = 1; B_WE = 1; B_ADDR = 12'h001; B_DI = 1;
        model_reset();
        #2;
        n_chk++;
        if ({BUSY, RAM_EN, RAM_WE, A_ACK, B_ACK, A_VLD, B_VLD, A_DO, B_DO} !== 9'b1_0000_0000) begin
            n_fail++; $display("FAIL reset_vec: got %b expected 100000000",
                {BUSY, RAM_EN, RAM_WE, A_ACK, B_ACK, A_VLD, B_VLD, A_DO, B_DO});
        end
        repeat (2) @(posedge CLK);
        #1; n_chk++;
        if ({BUSY, RAM_EN, A_ACK, B_ACK} !== 4'b1000) begin
            n_fail++; $display("FAIL reset_hold: got %b expected 1000", {BUSY, RAM_EN, A_ACK, B_ACK});
        end
        B_REQ = 0;
        @(negedge CLK); RST = 0;
    endtask

    task automatic test_clear_after_reset();
        test_clear_sweep(-1);
        n_chk++;
        if ({A_ACK, RAM_EN, RAM_WE, RAM_ADDR} !== {3'b110, 12'h7FF}) begin
            n_fail++; $display("FAIL first_idle_grant: got %b_%0h expected 110_7ff",
                {A_ACK, RAM_EN, RAM_WE}, RAM_ADDR);
        end
        model_commit(arb(A_REQ, B_REQ));
        @(negedge CLK); A_REQ = 0; #1;
        n_chk++;
        if ({A_VLD, A_DO, B_VLD} !== {1'b1, CV, 1'b0}) begin
            n_fail++; $display("FAIL clear_readback: got %b expected %b", {A_VLD, A_DO, B_VLD}, {1'b1, CV, 1'b0});
        end
        model_commit(0);
    endtask

    task automatic test_write_read();
        @(negedge CLK); A_REQ = 1; A_WE = 1; A_ADDR = 12'h123; A_DI = 1; #1;
        n_chk++;
        if ({A_ACK, RAM_WE, RAM_DI, RAM_ADDR} !== {3'b111, 12'h123}) begin
            n_fail++; $display("FAIL wr_grant: got %b_%0h expected 111_123", {A_ACK, RAM_WE, RAM_DI}, RAM_ADDR);
        end
        model_commit(1);
        @(negedge CLK); A_WE = 0; #1;
        n_chk++;
        if ({A_ACK, RAM_WE, A_VLD} !== 3'b100) begin
            n_fail++; $display("FAIL rd_grant: got %b expected 100", {A_ACK, RAM_WE, A_VLD});
        end
        model_commit(1);
        @(negedge CLK); A_REQ = 0; #1;
        n_chk++;
        if ({A_VLD, A_DO, B_VLD} !== 3'b110) begin
            n_fail++; $display("FAIL wr_then_rd: got %b expected 110", {A_VLD, A_DO, B_VLD});
        end
        model_commit(0);
        @(negedge CLK); #1;
        n_chk++;
        if ({A_VLD, A_DO, RAM_EN} !== 3'b010) begin
            n_fail++; $display("FAIL do_hold: got %b expected 010", {A_VLD, A_DO, RAM_EN});
        end
        model_commit(0);
    endtask

    task automatic test_random();
        bit a_hold = 0, b_hold = 0;
        int g;
        logic [AW+1:0] exp_ram;
        for (int c = 0; c < 400; c++) begin
            @(negedge CLK);
            if (!a_hold) begin
                A_REQ = ($urandom_range(0, 3) != 0); A_WE = 1'($urandom_range(0, 1));
                A_ADDR = AW'($urandom_range(0, 7)); A_DI = 1'($urandom_range(0, 1));
            end
            if (!b_hold) begin
                B_REQ = ($urandom_range(0, 3) != 0); B_WE = 1'($urandom_range(0, 1));
                B_ADDR = AW'($urandom_range(0, 7)); B_DI = 1'($urandom_range(0, 1));
            end
            #1;
            g = arb(A_REQ, B_REQ);
            exp_ram = (g == 1) ? {A_WE, A_ADDR, A_DI} :
                      (g == 2) ? {B_WE, B_ADDR, B_DI} : {1'b0, mdl_last_addr, mdl_last_di};
            n_chk++;
            if ({A_ACK, B_ACK, RAM_EN} !== {g == 1, g == 2, g != 0}) begin
                n_fail++; $display("FAIL rnd_grant c%0d: got %b expected %b", c, {A_ACK, B_ACK, RAM_EN},
                    {g == 1, g == 2, g != 0});
            end
            n_chk++;
            if ({RAM_WE, RAM_ADDR, RAM_DI} !== exp_ram) begin
                n_fail++; $display("FAIL rnd_ram c%0d: got %h expected %h", c, {RAM_WE, RAM_ADDR, RAM_DI}, exp_ram);
            end
            n_chk++;
            if ({A_VLD, A_DO, B_VLD, B_DO} !== {exp_avld, exp_ado, exp_bvld, exp_bdo}) begin
                n_fail++; $display("FAIL rnd_rdata c%0d: got %b expected %b", c, {A_VLD, A_DO, B_VLD, B_DO},
                    {exp_avld, exp_ado, exp_bvld, exp_bdo});
            end
            a_hold = A_REQ && (g != 1);
            b_hold = B_REQ && (g != 2);
            model_commit(g);
        end
    endtask

    task automatic test_alternate();
        int g, prev_g = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge CLK);
            A_REQ = (i < 6); B_REQ = (i < 6); A_WE = 0; B_WE = 0;
            if (prev_g != 2) A_ADDR = AW'($urandom_range(0, 7));
            if (prev_g != 1) B_ADDR = AW'($urandom_range(0, 7));
            #1;
            g = arb(A_REQ, B_REQ);
            n_chk++;
            if ({A_ACK, B_ACK} !== {g == 1, g == 2} || (i > 0 && i < 6 && g == prev_g)) begin
                n_fail++; $display("FAIL alt_grant %0d: got %b expected %b (prev %0d)", i, {A_ACK, B_ACK},
                    {g == 1, g == 2}, prev_g);
            end
            n_chk++;
            if ({A_VLD, A_DO, B_VLD, B_DO} !== {exp_avld, exp_ado, exp_bvld, exp_bdo}) begin
                n_fail++; $display("FAIL alt_rdata %0d: got %b expected %b", i, {A_VLD, A_DO, B_VLD, B_DO},
                    {exp_avld, exp_ado, exp_bvld, exp_bdo});
            end
            prev_g = g;
            model_commit(g);
        end
    endtask

    task automatic test_b_only();
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            A_REQ = 0; B_REQ = (i < 4); B_WE = 0; B_ADDR = AW'($urandom_range(0, 7));
            #1;
            n_chk++;
            if ({A_ACK, B_ACK} !== {1'b0, i < 4}) begin
                n_fail++; $display("FAIL b_only_ack %0d: got %b expected %b", i, {A_ACK, B_ACK}, {1'b0, i < 4});
            end
            n_chk++;
            if ({A_VLD, B_VLD, B_DO} !== {1'b0, i > 0, exp_bdo}) begin
                n_fail++; $display("FAIL b_only_vld %0d: got %b expected %b", i, {A_VLD, B_VLD, B_DO},
                    {1'b0, i > 0, exp_bdo});
            end
            model_commit(arb(A_REQ, B_REQ));
        end
    endtask

    task automatic test_clr_start();
        @(negedge CLK);
        A_REQ = 1; A_WE = 0; A_ADDR = 12'h005; B_REQ = 0; CLR_START = 1; #1;
        n_chk++;
        if ({A_ACK, RAM_EN, BUSY} !== 3'b000) begin
            n_fail++; $display("FAIL clr_start_cycle: got %b expected 000", {A_ACK, RAM_EN, BUSY});
        end
        model_commit(0);
        @(negedge CLK);
        test_clear_sweep(100);
        n_chk++;
        if ({A_ACK, RAM_EN, RAM_ADDR} !== {2'b11, 12'h005}) begin
            n_fail++; $display("FAIL post_clr_grant: got %b_%0h expected 11_005", {A_ACK, RAM_EN}, RAM_ADDR);
        end
        model_commit(arb(A_REQ, B_REQ));
        @(negedge CLK); A_REQ = 0; #1;
        n_chk++;
        if ({A_VLD, A_DO} !== {1'b1, CV}) begin
            n_fail++; $display("FAIL post_clr_read: got %b expected %b", {A_VLD, A_DO}, {1'b1, CV});
        end
        model_commit(0);
    endtask

    task automatic test_reset_mid_sweep();
        @(negedge CLK); A_REQ = 0; B_REQ = 0; CLR_START = 1;
        @(negedge CLK); CLR_START = 0;
        repeat (12'h800) @(negedge CLK);
        #1; n_chk++;
        if ({BUSY, RAM_ADDR} !== {1'b1, 12'h800}) begin
            n_fail++; $display("FAIL mid_sweep_pos: got %b_%0h expected 1_800", BUSY, RAM_ADDR);
        end
        #1 RST = 1; #1;
        n_chk++;
        if ({BUSY, RAM_EN, RAM_WE, A_ACK, B_ACK, A_VLD, B_VLD, A_DO, B_DO} !== 9'b1_0000_0000) begin
            n_fail++; $display("FAIL mid_reset_vec: got %b expected 100000000",
                {BUSY, RAM_EN, RAM_WE, A_ACK, B_ACK, A_VLD, B_VLD, A_DO, B_DO});
        end
        model_reset();
        @(posedge CLK); @(negedge CLK); RST = 0;
        test_clear_sweep(-1);
        n_chk++;
        if ({RAM_EN, RAM_ADDR} !== {1'b0, 12'hFFF}) begin
            n_fail++; $display("FAIL idle_addr_hold: got %b_%0h expected 0_fff", RAM_EN, RAM_ADDR);
        end
    endtask

    initial begin
        for (int i = 0; i < DEP; i++) ram_mem[i] = 1'($urandom_range(0, 1));
        RAM_DO = 1'b1;
        test_reset();
        test_clear_after_reset();
        test_write_read();
        test_random();
        test_alternate();
        test_b_only();
        test_clr_start();
        test_reset_mid_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/bram_s1_arbiter.md
Name: bram_s1_arbiter

Overview:
- Two-client round-robin arbiter and clear sequencer for one single-port 4096x1 block RAM.
- The RAM has synchronous read (1 cycle), write-first output, and EN/WE controls.
- Sits between two requesters (A, B) and the RAM primitive.
- Optionally sweeps the whole RAM to a constant after reset, or on command, before granting any client.

Parameters:
- ADDR_W, 12, RAM address width; depth = 2**ADDR_W.
- CLEAR_ON_RESET, 1, 1 = enter CLEAR state on reset release; 0 = enter IDLE.
- CLEAR_VAL, 1'b0, bit written to every location during CLEAR.

Ports:
- CLK  in  1  clock, all logic on posedge.
- RST  in  1  asynchronous active-high reset.
- CLR_START  in  1  pulse: start a clear sweep (ignored while BUSY).
- BUSY  out  1  high while in CLEAR.
- A_REQ  in  1  client A request.
- A_WE  in  1  client A write (1) / read (0).
- A_ADDR  in  ADDR_W  client A address.
- A_DI  in  1  client A write data.
- A_ACK  out  1  client A request accepted this cycle (combinational).
- A_VLD  out  1  client A read data valid (registered).
- A_DO  out  1  client A read data.
- B_REQ, B_WE, B_ADDR, B_DI, B_ACK, B_VLD, B_DO: same as A, for client B.
- RAM_EN  out  1  RAM enable.
- RAM_WE  out  1  RAM write enable.
- RAM_ADDR  out  ADDR_W  RAM address.
- RAM_DI  out  1  RAM write data.
- RAM_DO  in  1  RAM read data (valid one cycle after EN).

Behaviour:
- Reset (async, RST=1):
  - state = CLEAR if CLEAR_ON_RESET else IDLE.
  - Clear counter = 0; priority pointer = A.
  - A_VLD = B_VLD = 0; A_DO = B_DO = 0.
  - BUSY = CLEAR_ON_RESET.
  - RAM_EN = RAM_WE = 0; A_ACK = B_ACK = 0.
- States:
  - CLEAR: each cycle RAM_EN=1, RAM_WE=1, RAM_ADDR=counter, RAM_DI=CLEAR_VAL; counter increments.
  - CLEAR -> IDLE on the cycle counter = 2**ADDR_W-1 is written. Exactly 2**ADDR_W write cycles.
  - BUSY drops the following cycle.
  - IDLE: arbitration. IDLE -> CLEAR on CLR_START=1: counter reset to 0, BUSY=1 next cycle. No grant is issued in the CLR_START cycle.
- Arbitration (IDLE only, combinational from REQ and pointer):
  - Only one REQ high: grant that client.
  - Both high: grant the client named by the pointer.
  - Granted client: ACK=1; RAM_EN=1; RAM_WE/ADDR/DI = its WE/ADDR/DI.
  - No request: RAM_EN=0, RAM_WE=0; ADDR/DI hold last driven value.
  - Pointer update on posedge: after a grant, pointer = the other client. Otherwise unchanged.
  - One client requesting continuously is granted every cycle (no bubbles).
  - In CLEAR, both ACKs = 0; requests stall, are not dropped, and no state is queued.
- Read return:
  - A read granted in cycle t gives VLD=1 for that client in cycle t+1, with DO = RAM_DO.
  - Writes never raise VLD.
  - VLD is a one-cycle pulse per granted read.
  - DO holds its last value when VLD=0.
- Write-then-read, same address, consecutive grants (either client): the read returns the new data (RAM is write-first).
- Reset mid-CLEAR or mid-read: pending VLD is lost; sweep restarts at address 0.
- CLR_START while BUSY: ignored.
- Clients must hold REQ and the command fields until ACK is seen.

Test Plan:
- Reset with CLEAR_ON_RESET=1, ADDR_W=12 -> BUSY high for exactly 4096 cycles; RAM_WE=1 on addresses 0..4095 in order; no ACK meanwhile; then A read of 0x7FF -> A_VLD next cycle with A_DO=0.
- A writes 1 to 0x123; the next cycle A reads 0x123 -> A_ACK in both cycles; A_VLD one cycle after the read with A_DO=1; B_VLD stays 0.
- A_REQ and B_REQ held high for 6 reads -> grants alternate A,B,A,B,A,B; each client's VLD pulses one cycle after its own grant.
- Only B_REQ held for 4 cycles -> B_ACK=1 for 4 consecutive cycles; 4 consecutive B_VLD pulses.
- CLR_START pulse in IDLE with A_REQ high -> A_ACK=0 in that cycle and throughout the sweep; BUSY for 4096 cycles; A granted in the first IDLE cycle.
- RST asserted at sweep address 0x800 -> all outputs go to reset values immediately; after release the sweep restarts at 0x000 and runs the full 4096 cycles.
